// File: rtl/rd_serial_tx_pkg.sv
// Shared RD link definitions: frame geometry, transmitter state encoding and
// the per-lane parity rule.
package rd_interface_defs;

   localparam int unsigned RD_SAMPLE_BITS = 12;
   localparam int unsigned RD_FRAME_BITS  = 13;
   localparam int unsigned RD_NWORDS      = 2048;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_LEAD,
      ST_DATA,
      ST_TRAIL
   } rd_state_e;

   // Odd parity over sample plus parity bit; inj deliberately corrupts it.
   function automatic logic frame_parity(input logic [RD_SAMPLE_BITS-1:0] s,
                                         input logic inj);
      return ~(^s) ^ inj;
   endfunction

endpackage

// File: rtl/rd_tx_lane.sv
// One serial lane: loads a 12-bit sample, shifts it out MSB first and then
// appends its parity bit, one bit per load/step command.
module rd_tx_lane
   import rd_interface_defs::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic                      step,
   input  logic                      clear,
   input  logic                      inj,
   input  logic [RD_SAMPLE_BITS-1:0] sample,
   output logic                      last_bit,
   output logic                      sdata
);

   logic [RD_SAMPLE_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]                bcnt_q, bcnt_d;
   logic                      par_q, par_d;
   logic                      sdata_q, sdata_d;

   always_comb begin
      shreg_d = shreg_q;
      bcnt_d  = bcnt_q;
      par_d   = par_q;
      sdata_d = sdata_q;
      if (clear) begin
         sdata_d = 1'b0;
         bcnt_d  = '0;
      end else if (load) begin
         shreg_d = sample;
         bcnt_d  = '0;
         par_d   = frame_parity(sample, inj);
         sdata_d = sample[RD_SAMPLE_BITS-1];
      end else if (step) begin
         // shreg_q[10] always holds the bit that follows the one on the wire
         bcnt_d  = bcnt_q + 4'd1;
         shreg_d = {shreg_q[RD_SAMPLE_BITS-2:0], 1'b0};
         sdata_d = (bcnt_q == 4'(RD_SAMPLE_BITS - 1)) ? par_q
                                                       : shreg_q[RD_SAMPLE_BITS-2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q <= '0;
         bcnt_q  <= '0;
         par_q   <= 1'b0;
         sdata_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
         par_q   <= par_d;
         sdata_q <= sdata_d;
      end
   end

   assign last_bit = (bcnt_q == 4'(RD_FRAME_BITS - 1));
   assign sdata    = sdata_q;

endmodule

// File: rtl/rd_serial_tx.sv
// RD link transmitter: on trigger, streams a buffer of paired 12-bit samples
// as gated-clock serial frames on two lanes, all derived from CLK120.
module rd_serial_tx
   import rd_interface_defs::*;
#(
   parameter int unsigned DIV        = 1,
   parameter int unsigned NWORDS     = RD_NWORDS,
   parameter int unsigned TRIG_DELAY = 4,
   parameter int unsigned LEAD_CLKS  = 3,
   parameter int unsigned TRAIL_CLKS = 11
) (
   input  logic        CLK120,
   input  logic        RST_N,
   input  logic        TRIG_IN,
   input  logic [1:0]  PARITY_ERR_INJ,
   output logic [10:0] MEM_ADDR,
   input  logic [23:0] MEM_DATA,
   output logic        SERIAL_CLK_OUT,
   output logic        SERIAL_DATA0_OUT,
   output logic        SERIAL_DATA1_OUT,
   output logic        BUSY,
   output logic        DONE,
   output logic        TRIG_IGNORED
);

   localparam logic [7:0]  DIV_C     = 8'(DIV);
   localparam logic [7:0]  PER_M1    = 8'(2 * DIV - 1);
   localparam logic [15:0] DELAY_END = 16'(TRIG_DELAY);
   localparam logic [15:0] LEAD_END  = 16'(LEAD_CLKS - 1);
   localparam logic [15:0] TRAIL_END = 16'(TRAIL_CLKS - 1);
   localparam logic [11:0] LAST_WORD = 12'(NWORDS - 1);

   rd_state_e   state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [11:0] word_q, word_d;
   logic [10:0] addr_q, addr_d;
   logic        inc_q, inc_d;
   logic [1:0]  inj_q, inj_d;
   logic        trig_prev_q;
   logic        clk_q, clk_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ign_q, ign_d;

   logic        bit_end, word_end, serial_d;
   logic        load, step, clear;
   logic        last_bit0, last_bit1;

   assign bit_end  = (div_q == PER_M1);
   assign word_end = last_bit0 & last_bit1;

   always_ff @(posedge CLK120) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (TRIG_IN) state_d = ST_DELAY;
         ST_DELAY: if (cnt_q == DELAY_END) state_d = ST_LEAD;
         ST_LEAD:  if (bit_end && cnt_q == LEAD_END) state_d = ST_DATA;
         ST_DATA:  if (bit_end && word_end && word_q == LAST_WORD) state_d = ST_TRAIL;
         ST_TRAIL: if (bit_end && cnt_q == TRAIL_END) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      serial_d = state_d inside {ST_LEAD, ST_DATA, ST_TRAIL};

      // Bit phase restarts at 0 on entry to LEAD so the first low phase is DIV long
      div_d = '0;
      if (serial_d && (state_q inside {ST_LEAD, ST_DATA, ST_TRAIL}))
         div_d = bit_end ? 8'd0 : div_q + 8'd1;

      cnt_d = cnt_q;
      case (state_q)
         ST_DELAY: cnt_d = (state_d != ST_DELAY) ? 16'd0 : cnt_q + 16'd1;
         ST_LEAD, ST_TRAIL:
            if (bit_end) cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
         default:  cnt_d = '0;
      endcase

      clear = (state_d != ST_DATA);
      load  = (state_d == ST_DATA) && ((state_q == ST_LEAD) || (bit_end && word_end));
      step  = (state_q == ST_DATA) && bit_end && !word_end;

      word_d = word_q;
      if (state_q == ST_IDLE)      word_d = '0;
      else if (load)               word_d = (state_q == ST_LEAD) ? 12'd0 : word_q + 12'd1;

      // Address advances one cycle after each load, except after the final word
      inc_d  = load && (word_d != LAST_WORD);
      addr_d = addr_q;
      if (state_q == ST_IDLE || state_d == ST_IDLE) addr_d = '0;
      else if (inc_q)                               addr_d = addr_q + 11'd1;

      inj_d = (state_q == ST_IDLE && TRIG_IN) ? PARITY_ERR_INJ : inj_q;
   end

   always_comb begin
      clk_d  = serial_d && (div_d >= DIV_C);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_TRAIL) && (state_d == ST_IDLE);
      ign_d  = TRIG_IN && !trig_prev_q && (state_q != ST_IDLE);
   end

   always_ff @(posedge CLK120) begin
      if (!RST_N) begin
         div_q       <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         inc_q       <= 1'b0;
         inj_q       <= '0;
         trig_prev_q <= 1'b0;
         clk_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ign_q       <= 1'b0;
      end else begin
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         inc_q       <= inc_d;
         inj_q       <= inj_d;
         trig_prev_q <= TRIG_IN;
         clk_q       <= clk_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ign_q       <= ign_d;
      end
   end

   rd_tx_lane u_lane0 (
      .clk      (CLK120),
      .rst_n    (RST_N),
      .load     (load),
      .step     (step),
      .clear    (clear),
      .inj      (inj_q[0]),
      .sample   (MEM_DATA[11:0]),
      .last_bit (last_bit0),
      .sdata    (SERIAL_DATA0_OUT)
   );

   rd_tx_lane u_lane1 (
      .clk      (CLK120),
      .rst_n    (RST_N),
      .load     (load),
      .step     (step),
      .clear    (clear),
      .inj      (inj_q[1]),
      .sample   (MEM_DATA[23:12]),
      .last_bit (last_bit1),
      .sdata    (SERIAL_DATA1_OUT)
   );

   assign MEM_ADDR       = addr_q;
   assign SERIAL_CLK_OUT = clk_q;
   assign BUSY           = busy_q;
   assign DONE           = done_q;
   assign TRIG_IGNORED   = ign_q;

endmodule

// File: tb/tb_rd_serial_tx.sv
// Randomized scoreboard bench for rd_serial_tx: a receiver-side monitor
// deframes the serial lanes and compares against frames queued at trigger time.
module tb_rd_serial_tx;

   localparam int unsigned DIV   = 2;
   localparam int unsigned NW    = 20;
   localparam int unsigned TD    = 4;
   localparam int unsigned LC    = 3;
   localparam int unsigned TC    = 11;
   localparam int unsigned NCLK  = LC + 13 * NW + TC;
   localparam int unsigned TOTAL = NCLK * 2 * DIV;

   logic        CLK120 = 1'b0;
   logic        RST_N = 1'b0;
   logic        TRIG_IN = 1'b0;
   logic [1:0]  PARITY_ERR_INJ = 2'b00;
   logic [10:0] MEM_ADDR;
   logic [23:0] MEM_DATA = '0;
   logic        SERIAL_CLK_OUT, SERIAL_DATA0_OUT, SERIAL_DATA1_OUT;
   logic        BUSY, DONE, TRIG_IGNORED;

   logic [23:0] mem [0:2047];
   logic [25:0] exp_q [$];

   int unsigned n_checks = 0, n_pass = 0;
   int unsigned exp_done = 0, done_cnt = 0, ign_cnt = 0, busy_rises = 0;
   int unsigned last_done_cyc = 0, last_gap = 0;

   rd_serial_tx #(
      .DIV        (DIV),
      .NWORDS     (NW),
      .TRIG_DELAY (TD),
      .LEAD_CLKS  (LC),
      .TRAIL_CLKS (TC)
   ) dut (
      .CLK120           (CLK120),
      .RST_N            (RST_N),
      .TRIG_IN          (TRIG_IN),
      .PARITY_ERR_INJ   (PARITY_ERR_INJ),
      .MEM_ADDR         (MEM_ADDR),
      .MEM_DATA         (MEM_DATA),
      .SERIAL_CLK_OUT   (SERIAL_CLK_OUT),
      .SERIAL_DATA0_OUT (SERIAL_DATA0_OUT),
      .SERIAL_DATA1_OUT (SERIAL_DATA1_OUT),
      .BUSY             (BUSY),
      .DONE             (DONE),
      .TRIG_IGNORED     (TRIG_IGNORED)
   );

   always #5 CLK120 = ~CLK120;

   always @(posedge CLK120) MEM_DATA <= mem[MEM_ADDR];

   task automatic check(input string name, input longint act, input longint expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
   endtask

   // Reference frame: sample MSB first, then a bit making the 13-bit count of ones odd
   function automatic logic [12:0] frame(input logic [11:0] s, input logic inj);
      logic p;
      p = (($countones(s) % 2) == 0);
      return {s, p ^ inj};
   endfunction

   task automatic expect_transfer(input logic [1:0] inj);
      logic [23:0] w;
      for (int k = 0; k < int'(NW); k++) begin
         w = mem[k % 2048];
         exp_q.push_back({frame(w[23:12], inj[1]), frame(w[11:0], inj[0])});
      end
      exp_done++;
   endtask

   // Receiver model
   int unsigned cyc = 0, rx_idx = 0, busy_cyc = 0, run = 0, phase_err = 0, nonzero = 0;
   logic        pc = 1'b0, pd0 = 1'b0, pd1 = 1'b0, pb = 1'b0;
   logic [12:0] sh0 = '0, sh1 = '0;

   always @(negedge CLK120) begin
      cyc++;
      if (!RST_N) begin
         exp_q.delete();
         pc = 1'b0; pd0 = 1'b0; pd1 = 1'b0; pb = 1'b0; run = 0;
      end else begin
         if (BUSY && !pb) begin
            busy_cyc  = cyc;
            last_gap  = cyc - last_done_cyc;
            rx_idx    = 0;
            phase_err = 0;
            nonzero   = 0;
            busy_rises++;
         end
         if (TRIG_IGNORED) ign_cnt++;
         if ((SERIAL_DATA0_OUT != pd0 || SERIAL_DATA1_OUT != pd1) && !(pc && !SERIAL_CLK_OUT))
            phase_err++;
         if (SERIAL_CLK_OUT != pc) begin
            if (pc && run != DIV) phase_err++;
            else if (!pc && rx_idx != 0 && run != DIV) phase_err++;
            run = 1;
         end else begin
            run++;
         end
         if (SERIAL_CLK_OUT && !pc) begin
            if (rx_idx == 0) check("first_clk_delay", cyc - busy_cyc, TD + 1 + DIV);
            if (rx_idx < LC || rx_idx >= LC + 13 * NW) begin
               if (SERIAL_DATA0_OUT || SERIAL_DATA1_OUT) nonzero++;
               if (rx_idx == LC + 13 * NW) check("addr_held_last", MEM_ADDR, NW - 1);
            end else begin
               sh0 = {sh0[11:0], SERIAL_DATA0_OUT};
               sh1 = {sh1[11:0], SERIAL_DATA1_OUT};
               if ((rx_idx - LC) % 13 == 12) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     $display("FAIL word_unexpected: got 0x%0h expected none", {sh1, sh0});
                  end else begin
                     check($sformatf("word%0d", (rx_idx - LC) / 13), {sh1, sh0}, exp_q.pop_front());
                  end
               end
            end
            rx_idx++;
         end
         if (DONE) begin
            done_cnt++;
            last_done_cyc = cyc;
            check("done_latency", cyc - busy_cyc, TD + 1 + TOTAL);
            check("clk_count", rx_idx, NCLK);
            check("lead_trail_zero", nonzero, 0);
            check("phase_errors", phase_err, 0);
            check("words_left", exp_q.size(), 0);
         end
         pc = SERIAL_CLK_OUT; pd0 = SERIAL_DATA0_OUT; pd1 = SERIAL_DATA1_OUT; pb = BUSY;
      end
   end

   task automatic tick();
      @(posedge CLK120);
      #1;
   endtask

   task automatic trigger(input logic [1:0] inj);
      PARITY_ERR_INJ = inj;
      TRIG_IN = 1'b1;
      tick();
      TRIG_IN = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < int'(3 * TOTAL) && done_cnt < exp_done; i++) @(negedge CLK120);
      check(name, done_cnt, exp_done);
   endtask

   task automatic fill_random();
      for (int k = 0; k < 2048; k++) mem[k] = 24'($urandom);
   endtask

   int unsigned snap_done, snap_rises;

   initial begin
      for (int k = 0; k < 2048; k++) mem[k] = '0;
      RST_N = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {MEM_ADDR, SERIAL_CLK_OUT, SERIAL_DATA0_OUT, SERIAL_DATA1_OUT,
                              BUSY, DONE, TRIG_IGNORED}, 0);
      RST_N = 1'b1;
      repeat (3) tick();

      // Ramp buffer
      for (int k = 0; k < 2048; k++) mem[k] = {12'(4095 - k), 12'(k)};
      expect_transfer(2'b00);
      trigger(2'b00);
      wait_done("done_ramp");
      repeat (5) tick();
      check("addr_idle_zero", MEM_ADDR, 0);

      // Corner sample, lane-0 parity injection changed mid-run, ignored trigger
      fill_random();
      mem[0] = {12'h001, 12'h000};
      expect_transfer(2'b01);
      trigger(2'b01);
      repeat (200) tick();
      PARITY_ERR_INJ = 2'b00;
      repeat (100) tick();
      TRIG_IN = 1'b1;
      tick();
      TRIG_IN = 1'b0;
      wait_done("done_inject");
      repeat (40) tick();
      check("trig_ignored_cnt", ign_cnt, 1);
      check("no_second_transfer", busy_rises, 2);

      // Trigger held across the return to IDLE restarts immediately
      fill_random();
      expect_transfer(2'b10);
      PARITY_ERR_INJ = 2'b10;
      TRIG_IN = 1'b1;
      tick();
      repeat (100) tick();
      PARITY_ERR_INJ = 2'b11;
      wait_done("done_held_first");
      expect_transfer(2'b11);
      for (int i = 0; i < 20 && busy_rises < 4; i++) @(negedge CLK120);
      check("back_to_back_gap", last_gap, 1);
      tick();
      TRIG_IN = 1'b0;
      PARITY_ERR_INJ = 2'b00;
      wait_done("done_held_second");
      check("held_no_ignored", ign_cnt, 1);

      // Abort by reset mid-data
      repeat (10) tick();
      fill_random();
      expect_transfer(2'b00);
      trigger(2'b00);
      repeat (600) tick();
      RST_N = 1'b0;
      tick();
      check("abort_outputs", {SERIAL_CLK_OUT, SERIAL_DATA0_OUT, SERIAL_DATA1_OUT, BUSY, DONE}, 0);
      tick();
      RST_N = 1'b1;
      exp_done--;
      snap_done  = done_cnt;
      snap_rises = busy_rises;
      repeat (200) tick();
      check("abort_no_done", done_cnt, snap_done);
      check("abort_no_restart", busy_rises, snap_rises);

      // Full transfer after abort starts from address 0
      for (int k = 0; k < 2048; k++) mem[k] = {12'(4095 - k), 12'(k)};
      expect_transfer(2'b00);
      trigger(2'b00);
      wait_done("done_after_abort");

      repeat (10) tick();
      check("done_total", done_cnt, exp_done);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
